// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, occupancy states and the one-hot decode helper
package decoder_pkg;
  localparam int BIN_W_DEFAULT = 4;
  localparam int OUT_W_DEFAULT = 2 ** BIN_W_DEFAULT;
  localparam int MAX_BIN_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_BIN_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_state_t;
  // Sized for the widest code supported; callers truncate to their own OUT_W.
  function automatic logic [MAX_OUT_W-1:0] onehot_decode(input logic [MAX_BIN_W-1:0] code, input logic en);
    return en ? (MAX_OUT_W'(1) << code) : '0;
  endfunction
endpackage

// File: rtl/decoder_skid_fifo.sv
// decoder_skid_fifo: 2-entry valid/ready buffer, in-order, ready decoded from registered occupancy
module decoder_skid_fifo
  import decoder_pkg::*;
#(
  parameter int W = OUT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i
);
  occ_state_t state_q, state_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic push, pop;
  assign ready_o = !reset && state_q != FULL;
  assign valid_o = state_q != EMPTY;
  assign data_o = valid_o ? head_q : '0;
  assign push = valid_i && ready_o;
  assign pop = valid_o && ready_i;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: begin
        head_d = push ? data_i : head_q;
        state_d = push ? ONE : EMPTY;
      end
      ONE: begin
        head_d = (push && pop) ? data_i : head_q;
        tail_d = (push && !pop) ? data_i : tail_q;
        state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
      end
      FULL: begin
        head_d = pop ? tail_q : head_q;
        state_d = pop ? ONE : FULL;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/decoder_using_pipe.sv
// decoder_using_pipe: binary-to-one-hot decoder feeding a skid FIFO, counts delivered words
module decoder_using_pipe
  import decoder_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      binary_in,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2**BIN_W-1:0]   decoder_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      decode_count
);
  localparam int OUT_W = 2 ** BIN_W;
  logic [OUT_W-1:0] word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign word = OUT_W'(onehot_decode(MAX_BIN_W'(binary_in), enable));
  decoder_skid_fifo #(.W(OUT_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .data_i(word),
    .valid_i(in_valid),
    .ready_o(in_ready),
    .data_o(decoder_out),
    .valid_o(out_valid),
    .ready_i(out_ready)
  );
  assign cnt_d = cnt_q + CNT_W'(out_valid && out_ready);
  assign decode_count = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_decoder_using_pipe.sv
// tb_decoder_using_pipe: scenario tasks plus a scoreboard queue checked on every pop
module tb_decoder_using_pipe;
  logic clk = 1'b0;
  logic reset, enable, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] binary_in;
  logic [15:0] decoder_out;
  logic [7:0] decode_count;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [15:0] sb[$];

  decoder_using_pipe #(.BIN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .binary_in(binary_in), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .decoder_out(decoder_out),
    .out_valid(out_valid), .out_ready(out_ready), .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [15:0] exp;
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_order got %h expected no word", decoder_out);
        end else begin
          exp = sb.pop_front();
          if (decoder_out !== exp) begin
            errors++;
            $display("FAIL pop_order got %h expected %h", decoder_out, exp);
          end
        end
        exp_cnt++;
      end
      if (!out_valid) begin
        checks++;
        if (decoder_out !== 16'h0) begin
          errors++;
          $display("FAIL idle_zero got %h expected 0000", decoder_out);
        end
      end
      if (in_valid && in_ready) sb.push_back(enable ? (16'(1) << binary_in) : 16'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    enable = 1'b0;
    binary_in = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || decoder_out !== 16'h0 || decode_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b out=%h cnt=%0d expected 1 0 0000 0", in_ready, out_valid, decoder_out, decode_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; binary_in = 4'd5; enable = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0020) begin
      errors++;
      $display("FAIL single_latency got vld=%b out=%h expected 1 0020", out_valid, decoder_out);
    end
    tick();
    checks++;
    if (decode_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d expected 1", decode_count); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      binary_in = 4'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready code %0d got %b expected 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || decoder_out !== (16'(1) << i)) begin
        errors++;
        $display("FAIL stream_word code %0d got %h expected %h", i, decoder_out, 16'(1) << i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (decode_count !== 8'd16 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_count got cnt=%0d vld=%b expected 16 0", decode_count, out_valid);
    end
  endtask

  task automatic test_disable();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b0; binary_in = 4'bxxxx; enable = 1'bx;
    tick();
    in_valid = 1'b1; binary_in = 4'd9; enable = 1'b0;
    tick();
    in_valid = 1'b0; binary_in = 4'bxxxx; enable = 1'bx;
    checks++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0000) begin
      errors++;
      $display("FAIL disable_word got vld=%b out=%h expected 1 0000", out_valid, decoder_out);
    end
    tick();
    tick();
    checks++;
    if (decode_count !== 8'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL disable_count got cnt=%0d vld=%b expected 1 0", decode_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1; binary_in = 4'd3;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b expected 1", in_ready); end
    binary_in = 4'd7;
    tick();
    binary_in = 4'd1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || decoder_out !== 16'h0008) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got rdy=%b vld=%b out=%h expected 0 1 0008", i, in_ready, out_valid, decoder_out);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (decoder_out !== 16'h0080 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second got out=%h rdy=%b expected 0080 1", decoder_out, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (decoder_out !== 16'h0002) begin errors++; $display("FAIL bp_third got %h expected 0002", decoder_out); end
    tick();
    checks++;
    if (decode_count !== 8'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count got cnt=%0d vld=%b expected 3 0", decode_count, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1; binary_in = 4'd2;
    tick();
    binary_in = 4'd11;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got rdy=%b expected 0", in_ready); end
    do_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || decode_count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got vld=%b cnt=%0d rdy=%b expected 0 0 1", out_valid, decode_count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || decode_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_stale got vld=%b cnt=%0d expected 0 0", out_valid, decode_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      binary_in = 4'($urandom_range(0, 15));
      enable = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (decode_count !== 8'd1 || exp_cnt != 257) begin
      errors++;
      $display("FAIL wrap_count got %0d (seen %0d pops) expected 1 (257 pops)", decode_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_disable();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d words expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
